store_commit_arbiter: RTL and testbench

Sequences stores that leave the store reservation station (address already computed) into the data-memory write port.
- Holds up to DEPTH stores in program order in a circular queue.
- Releases a store to memory only after the ROB commits its robNum.
- Generates byte enables for SB/SH/SW and runs the single-outstanding req/ack write handshake.
- Flags load/store address hazards to the load path.
- On flush, discards uncommitted (speculative) stores.

---
 rtl/store_commit_arbiter_if.sv | 46 ++++
 rtl/store_commit_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_store_commit_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_commit_arbiter_if.sv
// Store queue handshake bundle: RS enqueue, ROB commit, memory write
// port, completion report and load-hazard probe.
interface store_commit_arbiter_if #(
    parameter int ROB_W = 6
);
    logic             st_valid;
    logic [ROB_W-1:0] st_rob;
    logic [31:0]      st_data;
    logic [31:0]      st_addr;
    logic [2:0]       st_subtype;
    logic             st_ready;
    logic             commit_valid;
    logic [ROB_W-1:0] commit_rob;
    logic             flush;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic             done_valid;
    logic [ROB_W-1:0] done_rob;
    logic [31:0]      ld_addr;
    logic             ld_hazard;

    modport master (
        output st_valid, st_rob, st_data, st_addr, st_subtype,
        input  st_ready,
        output commit_valid, commit_rob, flush,
        input  mem_req, mem_addr, mem_wdata, mem_be,
        output mem_ack,
        input  done_valid, done_rob,
        output ld_addr,
        input  ld_hazard
    );

    modport slave (
        input  st_valid, st_rob, st_data, st_addr, st_subtype,
        output st_ready,
        input  commit_valid, commit_rob, flush,
        output mem_req, mem_addr, mem_wdata, mem_be,
        input  mem_ack,
        output done_valid, done_rob,
        input  ld_addr,
        output ld_hazard
    );
endinterface

// File: rtl/store_commit_arbiter.sv
// In-order store queue: holds stores until ROB commit, then writes them
// one at a time through a req/ack port; flags same-word load hazards.
module store_commit_arbiter #(
    parameter int               DEPTH       = 4,
    parameter int               ROB_W       = 6,
    parameter logic [ROB_W-1:0] INVALID_ROB = 6'b010000
) (
    input  logic                 clock,
    input  logic                 reset,
    store_commit_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [ROB_W-1:0] e_rob  [DEPTH];
    logic [29:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [3:0]       e_be   [DEPTH];
    logic [DEPTH-1:0] e_cmt;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [PW:0]      kept;
    logic             enq;
    logic             pop;
    logic             start;
    logic [3:0]       lane_be;
    logic [31:0]      lane_data;

    assign bus.st_ready = (count != (PW+1)'(DEPTH));
    assign enq = bus.st_valid && bus.st_ready && !bus.flush;

    // Entry liveness, commit matches and the committed-prefix length kept by a flush
    always_comb begin
        live = '0;
        hit  = '0;
        kept = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = {1'b0, PW'(PW'(i) - head)} < count;
            hit[i]  = bus.commit_valid && live[i] &&
                      (e_rob[i] == bus.commit_rob);
            kept    = kept + (PW+1)'(live[i] & (e_cmt[i] | hit[i]));
        end
    end

    // Byte lanes and replicated data from subtype and low address bits
    always_comb begin
        lane_be   = 4'b1111;
        lane_data = bus.st_data;
        case (bus.st_subtype)
            3'b000: begin
                lane_be   = 4'b0001 << bus.st_addr[1:0];
                lane_data = {4{bus.st_data[7:0]}};
            end
            3'b001: begin
                lane_be   = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load probe hits any live entry in the same word, including the one being written
    always_comb begin
        bus.ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && e_addr[i] == bus.ld_addr[31:2]) begin
                bus.ld_hazard = 1'b1;
            end
        end
    end

    // Entry payload is written at the tail on enqueue
    always_ff @(posedge clock) begin
        if (enq) begin
            e_rob[tail]  <= bus.st_rob;
            e_addr[tail] <= bus.st_addr[31:2];
            e_data[tail] <= lane_data;
            e_be[tail]   <= lane_be;
        end
    end

    // Commit bits: set on tag match; a new entry may arrive already committed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            e_cmt <= '0;
        end else begin
            e_cmt <= e_cmt | hit;
            if (enq) begin
                e_cmt[tail] <= bus.commit_valid &&
                               (bus.commit_rob == bus.st_rob);
            end
        end
    end

    // Head/tail/count; a flush truncates the queue to its committed prefix
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + 1'b1;
            end
            if (bus.flush) begin
                tail  <= head + kept[PW-1:0];
                count <= kept - (PW+1)'(pop);
            end else begin
                if (enq) begin
                    tail <= tail + 1'b1;
                end
                count <= count + (PW+1)'(enq) - (PW+1)'(pop);
            end
        end
    end

    // Writer state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Writer next state: start on committed head, pop on ack, one idle-recovery cycle
    always_comb begin
        state_next = state;
        start      = 1'b0;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0 && e_cmt[head]) begin
                    start      = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    pop        = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered memory request and completion report
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_be     <= '0;
            bus.done_valid <= 1'b0;
            bus.done_rob   <= INVALID_ROB;
        end else begin
            if (start) begin
                bus.mem_req   <= 1'b1;
                bus.mem_addr  <= {e_addr[head], 2'b00};
                bus.mem_wdata <= e_data[head];
                bus.mem_be    <= e_be[head];
            end
            if (pop) begin
                bus.mem_req    <= 1'b0;
                bus.done_valid <= 1'b1;
                bus.done_rob   <= e_rob[head];
            end
            if (state == DONE) begin
                bus.done_valid <= 1'b0;
                bus.done_rob   <= INVALID_ROB;
            end
        end
    end

    // The reservation station must never offer a store into a full queue
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(bus.st_valid && !bus.st_ready))
            else $error("store offered while queue full");
        end
    end
endmodule

// File: tb/tb_store_commit_arbiter.sv
// Bench for store_commit_arbiter: directed literal scenarios plus a
// randomized run checked every cycle against a queue-based model.
module tb_store_commit_arbiter;
    localparam int         DEPTH = 4;
    localparam logic [5:0] INV   = 6'd16;

    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        cmt;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    store_commit_arbiter_if #(.ROB_W(6)) bus ();

    store_commit_arbiter #(
        .DEPTH(DEPTH),
        .ROB_W(6),
        .INVALID_ROB(INV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    ent_t        q[$];
    bit          m_busy;
    bit          m_done;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_dv;
    logic [5:0]  exp_drob;
    logic [5:0]  done_log[$];
    int          req_rises;
    logic        prev_req;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [5:0]  next_rob = 6'd20;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void lanes(input logic [2:0] st, input logic [31:0] a,
                                  input logic [31:0] d, output logic [3:0] be,
                                  output logic [31:0] w);
        case (st)
            3'd0: begin be = 4'b0001 << a[1:0]; w = {4{d[7:0]}}; end
            3'd1: begin be = a[1] ? 4'b1100 : 4'b0011; w = {2{d[15:0]}}; end
            default: begin be = 4'hF; w = d; end
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy    = 0;
        m_done    = 0;
        exp_req   = 0;
        exp_addr  = 0;
        exp_wdata = 0;
        exp_be    = 0;
        exp_dv    = 0;
        exp_drob  = INV;
    endtask

    task automatic model_step();
        ent_t e;
        bit ready = (q.size() != DEPTH);
        bit pop   = m_busy && bus.mem_ack;
        bit start = !m_busy && !m_done && q.size() > 0 && q[0].cmt;
        if (m_done) begin
            m_done   = 0;
            exp_dv   = 0;
            exp_drob = INV;
        end
        if (pop) begin
            exp_req  = 0;
            exp_dv   = 1;
            exp_drob = q[0].rob;
            m_busy   = 0;
            m_done   = 1;
        end
        if (start) begin
            m_busy    = 1;
            exp_req   = 1;
            exp_addr  = {q[0].addr[31:2], 2'b00};
            exp_wdata = q[0].data;
            exp_be    = q[0].be;
        end
        if (bus.commit_valid) begin
            foreach (q[i]) if (q[i].rob == bus.commit_rob) q[i].cmt = 1;
        end
        if (pop) void'(q.pop_front());
        if (bus.flush) begin
            while (q.size() > 0 && !q[q.size()-1].cmt) void'(q.pop_back());
        end else if (bus.st_valid && ready) begin
            e.rob  = bus.st_rob;
            e.addr = bus.st_addr;
            lanes(bus.st_subtype, bus.st_addr, bus.st_data, e.be, e.data);
            e.cmt  = bus.commit_valid && (bus.commit_rob == bus.st_rob);
            q.push_back(e);
        end
    endtask

    task automatic compare();
        bit hz = 0;
        foreach (q[i]) if (q[i].addr[31:2] == bus.ld_addr[31:2]) hz = 1;
        check("st_ready", bus.st_ready, 32'(q.size() != DEPTH));
        check("mem_req", bus.mem_req, exp_req);
        if (exp_req) begin
            check("mem_addr", bus.mem_addr, exp_addr);
            check("mem_wdata", bus.mem_wdata, exp_wdata);
            check("mem_be", bus.mem_be, exp_be);
        end
        check("done_valid", bus.done_valid, exp_dv);
        check("done_rob", bus.done_rob, exp_drob);
        check("ld_hazard", bus.ld_hazard, hz);
        if (bus.done_valid === 1'b1) done_log.push_back(bus.done_rob);
        if (bus.mem_req === 1'b1 && prev_req !== 1'b1) req_rises++;
        prev_req = bus.mem_req;
    endtask

    task automatic clear_inputs();
        bus.st_valid     = 0;
        bus.commit_valid = 0;
        bus.flush        = 0;
        bus.mem_ack      = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        clear_inputs();
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        model_reset();
        done_log.delete();
        req_rises = 0;
        prev_req  = 0;
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
    endtask

    task automatic put_store(input logic [5:0] rob, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] st);
        bus.st_valid   = 1;
        bus.st_rob     = rob;
        bus.st_addr    = a;
        bus.st_data    = d;
        bus.st_subtype = st;
    endtask

    task automatic do_commit(input logic [5:0] rob);
        bus.commit_valid = 1;
        bus.commit_rob   = rob;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q.size() > 0 || m_busy || m_done) && n < limit) begin
            bus.mem_ack = exp_req;
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < limit), 1);
    endtask

    initial begin
        clear_inputs();
        bus.st_rob     = 0;
        bus.st_addr    = 0;
        bus.st_data    = 0;
        bus.st_subtype = 0;
        bus.commit_rob = 0;
        bus.ld_addr    = 0;
        do_reset();

        check("rst_req", bus.mem_req, 0);
        check("rst_be", bus.mem_be, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_done_rob", bus.done_rob, 16);
        check("rst_ready", bus.st_ready, 1);
        check("rst_hazard", bus.ld_hazard, 0);

        put_store(3, 32'h100, 32'hDEADBEEF, 3'd2);
        tick();
        do_commit(3);
        tick();
        check("sw_req_early", bus.mem_req, 0);
        tick();
        check("sw_req", bus.mem_req, 1);
        check("sw_addr", bus.mem_addr, 32'h100);
        check("sw_be", bus.mem_be, 4'b1111);
        check("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        bus.mem_ack = 1;
        tick();
        check("sw_done", bus.done_valid, 1);
        check("sw_done_rob", bus.done_rob, 3);
        check("sw_req_off", bus.mem_req, 0);
        tick();
        check("sw_done_end", bus.done_valid, 0);
        check("sw_done_inv", bus.done_rob, 16);

        put_store(4, 32'h203, 32'h5A, 3'd0);
        do_commit(4);
        tick();
        tick();
        check("sb_addr", bus.mem_addr, 32'h200);
        check("sb_be", bus.mem_be, 4'b1000);
        check("sb_wdata", bus.mem_wdata, 32'h5A5A5A5A);
        bus.mem_ack = 1;
        tick();
        tick();
        put_store(5, 32'h206, 32'h1234, 3'd1);
        do_commit(5);
        tick();
        tick();
        check("sh_addr", bus.mem_addr, 32'h204);
        check("sh_be", bus.mem_be, 4'b1100);
        check("sh_wdata", bus.mem_wdata, 32'h12341234);
        bus.mem_ack = 1;
        tick();
        tick();

        do_reset();
        for (int k = 1; k <= 4; k++) begin
            put_store(6'(k), 32'h300 + 32'(k * 4), 32'(k), 3'd2);
            tick();
        end
        check("full_ready", bus.st_ready, 0);
        do_commit(1);
        tick();
        tick();
        check("full_req", bus.mem_req, 1);
        check("full_still", bus.st_ready, 0);
        bus.mem_ack = 1;
        tick();
        check("ready_after_pop", bus.st_ready, 1);
        put_store(5, 32'h314, 32'h5, 3'd2);
        tick();
        for (int k = 2; k <= 5; k++) begin
            do_commit(6'(k));
            tick();
        end
        drain(60);
        check("wrap_count", done_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("wrap_order", k < done_log.size() ? done_log[k] : 6'd0, k + 1);
        end

        do_reset();
        put_store(7, 32'h500, 32'h77, 3'd2);
        do_commit(7);
        tick();
        put_store(8, 32'h504, 32'h88, 3'd2);
        tick();
        put_store(9, 32'h508, 32'h99, 3'd2);
        tick();
        put_store(10, 32'h50C, 32'hAA, 3'd2);
        bus.flush = 1;
        tick();
        check("flush_ready", bus.st_ready, 1);
        drain(20);
        check("flush_count", done_log.size(), 1);
        check("flush_rob", done_log.size() > 0 ? done_log[0] : 6'd0, 7);
        check("flush_reqs", req_rises, 1);

        do_reset();
        bus.ld_addr = 32'h42;
        put_store(12, 32'h40, 32'h12, 3'd2);
        do_commit(12);
        tick();
        check("hz_same_word", bus.ld_hazard, 1);
        check("hz_req_early", bus.mem_req, 0);
        bus.ld_addr = 32'h44;
        #1;
        check("hz_next_word", bus.ld_hazard, 0);
        tick();
        check("c12_req", bus.mem_req, 1);
        bus.ld_addr = 32'h40;
        #1;
        check("hz_in_write", bus.ld_hazard, 1);
        reset = 1;
        #1;
        check("rmw_req", bus.mem_req, 0);
        check("rmw_ready", bus.st_ready, 1);
        check("rmw_done", bus.done_valid, 0);
        check("rmw_done_rob", bus.done_rob, 16);
        check("rmw_hazard", bus.ld_hazard, 0);
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            int fu = -1;
            int r;
            foreach (q[i]) if (!q[i].cmt && fu < 0) fu = i;
            if (q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                put_store(next_rob, 32'h100 + $urandom_range(0, 31), $urandom,
                          3'($urandom_range(0, 7)));
                next_rob = next_rob + 1;
                if (next_rob == 6'd16) next_rob = 6'd17;
                if (next_rob == 6'd63) next_rob = 6'd0;
            end
            r = $urandom_range(0, 9);
            if (fu >= 0 && r < 5) do_commit(q[fu].rob);
            else if (fu < 0 && bus.st_valid && r < 5) do_commit(bus.st_rob);
            else if (r == 9) do_commit(6'd63);
            bus.flush   = ($urandom_range(0, 19) == 0);
            bus.mem_ack = ($urandom_range(0, 2) == 0);
            bus.ld_addr = 32'h100 + $urandom_range(0, 35);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
